// File: rtl/keypad_entry.sv
// Keypad entry: synchronises and debounces scanner key events, then edits a BCD entry
// register (digit shift-in, backspace, clear, enter) and strobes committed values.
module keypad_entry #(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Down,
    input  logic [3:0]            Button,
    output logic [4*DIGITS-1:0]   Entry,
    output logic [3:0]            Count,
    output logic                  Overflow,
    output logic [4*DIGITS-1:0]   Value,
    output logic                  Valid,
    output logic                  Func,
    output logic [3:0]            FuncCode
);

    localparam int unsigned CntW = $clog2(DEBOUNCE + 1);
    localparam int unsigned EW   = 4 * DIGITS;
    localparam logic [CntW:0] DebLim = DEBOUNCE[CntW:0];
    localparam logic [3:0]    CntMax = DIGITS[3:0];

    typedef enum logic [1:0] {StIdle, StArm, StHeld, StRel} state_e;

    logic            down_s1_q, down_s2_q;
    logic [3:0]      btn_s1_q, btn_s2_q;
    logic            blocked_q;
    logic [1:0]      fill_q;
    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [CntW:0]   cnt_inc;
    logic            key_evt;
    logic            evt_q;
    logic [3:0]      code_q;

    logic [EW-1:0]   entry_q, entry_d;
    logic [EW+3:0]   entry_shl;
    logic [3:0]      count_q, count_d;
    logic            ovf_q, ovf_d;
    logic [EW-1:0]   value_q, value_d;
    logic            valid_q, valid_d;
    logic            func_q, func_d;
    logic [3:0]      fcode_q, fcode_d;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            down_s1_q <= 1'b0;
            down_s2_q <= 1'b0;
            btn_s1_q  <= 4'h0;
            btn_s2_q  <= 4'h0;
            blocked_q <= 1'b1;
            fill_q    <= 2'd0;
        end else begin
            down_s1_q <= Down;
            down_s2_q <= down_s1_q;
            btn_s1_q  <= Button;
            btn_s2_q  <= btn_s1_q;
            if (fill_q != 2'd2) begin
                fill_q <= fill_q + 2'd1;
            end
            // A key held through reset stays ignored until the refilled sync chain shows it low
            if (fill_q == 2'd2 && !down_s2_q) begin
                blocked_q <= 1'b0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        key_evt = 1'b0;
        cnt_inc = {1'b0, cnt_q} + 1'b1;
        unique case (state_q)
            StIdle: begin
                if (down_s2_q && !blocked_q) begin
                    if (DEBOUNCE == 1) begin
                        state_d = StHeld;
                        key_evt = 1'b1;
                    end else begin
                        state_d = StArm;
                        cnt_d   = CntW'(1);
                    end
                end
            end
            StArm: begin
                if (!down_s2_q) begin
                    state_d = StIdle;
                end else if (cnt_inc >= DebLim) begin
                    state_d = StHeld;
                    key_evt = 1'b1;
                end else begin
                    cnt_d = cnt_inc[CntW-1:0];
                end
            end
            StHeld: begin
                if (!down_s2_q) begin
                    if (DEBOUNCE == 1) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StRel;
                        cnt_d   = CntW'(1);
                    end
                end
            end
            StRel: begin
                if (down_s2_q) begin
                    state_d = StHeld;
                end else if (cnt_inc >= DebLim) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_inc[CntW-1:0];
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            evt_q   <= 1'b0;
            code_q  <= 4'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            evt_q   <= key_evt;
            code_q  <= btn_s2_q;
        end
    end

    always_comb begin
        entry_d   = entry_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        value_d   = value_q;
        valid_d   = 1'b0;
        func_d    = 1'b0;
        fcode_d   = fcode_q;
        entry_shl = {entry_q, code_q};
        if (evt_q) begin
            if (code_q <= 4'd9) begin
                if (count_q < CntMax) begin
                    entry_d = entry_shl[EW-1:0];
                    count_d = count_q + 4'd1;
                end else begin
                    ovf_d = 1'b1;
                end
            end else begin
                case (code_q)
                    4'hA: begin
                        if (count_q != 4'd0) begin
                            entry_d = entry_q >> 4;
                            count_d = count_q - 4'd1;
                        end
                    end
                    4'hB: begin
                        entry_d = '0;
                        count_d = 4'd0;
                        ovf_d   = 1'b0;
                    end
                    4'hE: begin
                        if (count_q != 4'd0) begin
                            value_d = entry_q;
                            valid_d = 1'b1;
                            entry_d = '0;
                            count_d = 4'd0;
                            ovf_d   = 1'b0;
                        end
                    end
                    default: begin
                        func_d  = 1'b1;
                        fcode_d = code_q;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            entry_q <= '0;
            count_q <= 4'd0;
            ovf_q   <= 1'b0;
            value_q <= '0;
            valid_q <= 1'b0;
            func_q  <= 1'b0;
            fcode_q <= 4'h0;
        end else begin
            entry_q <= entry_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            value_q <= value_d;
            valid_q <= valid_d;
            func_q  <= func_d;
            fcode_q <= fcode_d;
        end
    end

    assign Entry    = entry_q;
    assign Count    = count_q;
    assign Overflow = ovf_q;
    assign Value    = value_q;
    assign Valid    = valid_q;
    assign Func     = func_q;
    assign FuncCode = fcode_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: directed vector table, hand-written timing corner cases and
// randomized presses checked against a digit-queue reference model.
module tb_keypad_entry;

    localparam int unsigned DIGITS   = 4;
    localparam int unsigned DEBOUNCE = 4;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Down;
    logic [3:0]  Button;
    logic [15:0] Entry;
    logic [3:0]  Count;
    logic        Overflow;
    logic [15:0] Value;
    logic        Valid;
    logic        Func;
    logic [3:0]  FuncCode;

    always #5 Clk = ~Clk;

    keypad_entry #(
        .DIGITS  (DIGITS),
        .DEBOUNCE(DEBOUNCE)
    ) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .Down    (Down),
        .Button  (Button),
        .Entry   (Entry),
        .Count   (Count),
        .Overflow(Overflow),
        .Value   (Value),
        .Valid   (Valid),
        .Func    (Func),
        .FuncCode(FuncCode)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic press(input logic [3:0] code, input int hi, input int lo);
        Button = code;
        Down   = 1'b1;
        repeat (hi) tick();
        Down = 1'b0;
        repeat (lo) tick();
    endtask

    // Strobe monitor: counts pulses and flags stretched, overlapping or stale-digit states
    bit   mon_en = 1'b0;
    int   valid_pulses = 0;
    int   func_pulses = 0;
    int   strobe_err = 0;
    int   inv_err = 0;
    logic pv = 1'b0;
    logic pf = 1'b0;

    always @(negedge Clk) begin
        if (mon_en) begin
            if (Valid) valid_pulses++;
            if (Func) func_pulses++;
            if ((Valid && Func) || (Valid && pv) || (Func && pf)) strobe_err++;
            pv = Valid;
            pf = Func;
            if (Count > DIGITS) begin
                inv_err++;
            end else begin
                for (int i = 0; i < int'(DIGITS); i++) begin
                    if (i >= int'(Count) && Entry[4*i +: 4] != 4'h0) inv_err++;
                end
            end
        end
    end

    // Reference model: entered digits as a queue, oldest first
    int          dq[$];
    bit          m_ovf;
    logic [15:0] m_value;
    logic [3:0]  m_fc;
    int          m_vexp;
    int          m_fexp;

    function automatic logic [15:0] m_entry();
        logic [15:0] r = 16'h0;
        for (int i = 0; i < dq.size(); i++) r = (r << 4) | 16'(dq[i]);
        return r;
    endfunction

    task automatic model_reset();
        dq.delete();
        m_ovf   = 1'b0;
        m_value = 16'h0;
        m_fc    = 4'h0;
    endtask

    task automatic model_key(input int code);
        m_vexp = 0;
        m_fexp = 0;
        if (code <= 9) begin
            if (dq.size() < int'(DIGITS)) dq.push_back(code);
            else m_ovf = 1'b1;
        end else if (code == 10) begin
            if (dq.size() > 0) void'(dq.pop_back());
        end else if (code == 11) begin
            dq.delete();
            m_ovf = 1'b0;
        end else if (code == 14) begin
            if (dq.size() > 0) begin
                m_value = m_entry();
                m_vexp  = 1;
                dq.delete();
                m_ovf = 1'b0;
            end
        end else begin
            m_fexp = 1;
            m_fc   = 4'(code);
        end
    endtask

    typedef struct {
        logic [3:0]  code;
        logic [15:0] entry;
        logic [3:0]  count;
        logic        ovf;
        logic [15:0] value;
        logic [3:0]  fc;
        int          vp;
        int          fp;
    } vec_t;

    vec_t tbl[$];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int vp0;
        int fp0;
        int code;
        int hi;
        int lo;

        tbl.push_back('{4'h2, 16'h0012, 4'd2, 1'b0, 16'h0000, 4'h0, 0, 0});
        tbl.push_back('{4'h3, 16'h0123, 4'd3, 1'b0, 16'h0000, 4'h0, 0, 0});
        tbl.push_back('{4'hB, 16'h0000, 4'd0, 1'b0, 16'h0000, 4'h0, 0, 0});
        tbl.push_back('{4'h4, 16'h0004, 4'd1, 1'b0, 16'h0000, 4'h0, 0, 0});
        tbl.push_back('{4'h5, 16'h0045, 4'd2, 1'b0, 16'h0000, 4'h0, 0, 0});
        tbl.push_back('{4'h6, 16'h0456, 4'd3, 1'b0, 16'h0000, 4'h0, 0, 0});
        tbl.push_back('{4'h7, 16'h4567, 4'd4, 1'b0, 16'h0000, 4'h0, 0, 0});
        tbl.push_back('{4'h8, 16'h4567, 4'd4, 1'b1, 16'h0000, 4'h0, 0, 0});
        tbl.push_back('{4'hE, 16'h0000, 4'd0, 1'b0, 16'h4567, 4'h0, 1, 0});
        tbl.push_back('{4'h9, 16'h0009, 4'd1, 1'b0, 16'h4567, 4'h0, 0, 0});
        tbl.push_back('{4'h8, 16'h0098, 4'd2, 1'b0, 16'h4567, 4'h0, 0, 0});
        tbl.push_back('{4'hA, 16'h0009, 4'd1, 1'b0, 16'h4567, 4'h0, 0, 0});
        tbl.push_back('{4'hA, 16'h0000, 4'd0, 1'b0, 16'h4567, 4'h0, 0, 0});
        tbl.push_back('{4'hA, 16'h0000, 4'd0, 1'b0, 16'h4567, 4'h0, 0, 0});
        tbl.push_back('{4'hE, 16'h0000, 4'd0, 1'b0, 16'h4567, 4'h0, 0, 0});
        tbl.push_back('{4'hD, 16'h0000, 4'd0, 1'b0, 16'h4567, 4'hD, 0, 1});
        tbl.push_back('{4'h7, 16'h0007, 4'd1, 1'b0, 16'h4567, 4'hD, 0, 0});
        tbl.push_back('{4'hB, 16'h0000, 4'd0, 1'b0, 16'h4567, 4'hD, 0, 0});

        Reset  = 1'b1;
        Down   = 1'b0;
        Button = 4'h0;
        repeat (3) tick();
        Reset = 1'b0;
        mon_en = 1'b1;
        check("reset_entry", Entry, 0);
        check("reset_count", Count, 0);
        check("reset_ovf", Overflow, 0);
        check("reset_value", Value, 0);
        check("reset_valid", Valid, 0);
        check("reset_func", Func, 0);
        check("reset_fcode", FuncCode, 0);
        repeat (3) tick();

        // Update lands on the edge 2+DEBOUNCE after the first edge sampling Down high
        Button = 4'h1;
        Down   = 1'b1;
        repeat (6) tick();
        check("latency_early_count", Count, 0);
        tick();
        check("latency_count", Count, 1);
        check("latency_entry", Entry, 16'h0001);
        repeat (3) tick();
        Down = 1'b0;
        repeat (10) tick();

        foreach (tbl[i]) begin
            vp0 = valid_pulses;
            fp0 = func_pulses;
            press(tbl[i].code, 10, 10);
            check($sformatf("tbl%0d_entry", i), Entry, tbl[i].entry);
            check($sformatf("tbl%0d_count", i), Count, tbl[i].count);
            check($sformatf("tbl%0d_ovf", i), Overflow, tbl[i].ovf);
            check($sformatf("tbl%0d_value", i), Value, tbl[i].value);
            check($sformatf("tbl%0d_fcode", i), FuncCode, tbl[i].fc);
            check($sformatf("tbl%0d_valid_pulses", i), valid_pulses - vp0, tbl[i].vp);
            check($sformatf("tbl%0d_func_pulses", i), func_pulses - fp0, tbl[i].fp);
        end

        // Short glitch, then a press with a brief release dip
        vp0 = valid_pulses;
        fp0 = func_pulses;
        press(4'h5, 3, 10);
        check("glitch_count", Count, 0);
        Button = 4'h6;
        Down   = 1'b1;
        repeat (8) tick();
        Down = 1'b0;
        repeat (3) tick();
        Down = 1'b1;
        repeat (9) tick();
        Down = 1'b0;
        repeat (10) tick();
        check("dip_entry", Entry, 16'h0006);
        check("dip_count", Count, 1);
        check("dip_pulses", (valid_pulses - vp0) + (func_pulses - fp0), 0);

        // Reset while the press is still being debounced
        Button = 4'h3;
        Down   = 1'b1;
        repeat (4) tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("armrst_entry", Entry, 0);
        check("armrst_count", Count, 0);
        check("armrst_value", Value, 0);
        check("armrst_fcode", FuncCode, 0);
        repeat (20) tick();
        check("armrst_held_count", Count, 0);
        Down = 1'b0;
        repeat (10) tick();
        press(4'h3, 10, 10);
        check("armrst_repress_entry", Entry, 16'h0003);
        check("armrst_repress_count", Count, 1);

        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        model_reset();
        repeat (4) tick();
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                press(4'($urandom_range(0, 15)), int'($urandom_range(1, DEBOUNCE - 1)),
                      int'($urandom_range(DEBOUNCE, DEBOUNCE + 4)));
            end
            code = int'($urandom_range(0, 9));
            if ($urandom_range(0, 2) == 0) code = 10 + int'($urandom_range(0, 5));
            hi = int'($urandom_range(DEBOUNCE, DEBOUNCE + 8));
            lo = int'($urandom_range(DEBOUNCE + 1, DEBOUNCE + 8));
            vp0 = valid_pulses;
            fp0 = func_pulses;
            press(4'(code), hi, lo);
            model_key(code);
            check($sformatf("rnd%0d_entry", n), Entry, m_entry());
            check($sformatf("rnd%0d_count", n), Count, dq.size());
            check($sformatf("rnd%0d_ovf", n), Overflow, m_ovf);
            check($sformatf("rnd%0d_value", n), Value, m_value);
            check($sformatf("rnd%0d_fcode", n), FuncCode, m_fc);
            check($sformatf("rnd%0d_valid_pulses", n), valid_pulses - vp0, m_vexp);
            check($sformatf("rnd%0d_func_pulses", n), func_pulses - fp0, m_fexp);
        end

        check("strobe_rules", strobe_err, 0);
        check("entry_upper_zero", inv_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
